// File: rtl/plru_way_controller.sv
// -----------------------------------------------------------------------------
// plru_way_controller
//
// Way-selection sequencer for one cache bank. A lookup result (set index,
// one-hot hit vector, invalid-way vector) is accepted over a valid/ready
// handshake. A hit is encoded to a way index. On a miss a victim is picked
// from per-set tree pseudo-LRU state. The chosen way is returned over a
// second valid/ready handshake.
//
// Each lookup walks a fixed four-state sequence:
//   IDLE   : req_ready=1, capture the request
//   READ   : fetch the PLRU bits of the captured set
//   DECIDE : encode/choose the way, write back the PLRU bits, load response
//   RESP   : resp_valid=1 until the consumer takes it
//
// Optional feature macro: PLRU_INVALID_FIRST_EN
//   defined   - a miss with any invalid way picks the lowest-index invalid way
//   undefined - req_invalid_vec is ignored, a miss always takes the PLRU victim
//
// Ports:
//   clk             in   clock, rising edge
//   reset           in   synchronous active-high reset
//   req_valid       in   lookup request present
//   req_ready       out  block can accept a request (IDLE only)
//   req_set         in   [SET_W-1:0] set index
//   req_hit_vec     in   [WAYS-1:0]  tag-match vector (all zero = miss)
//   req_invalid_vec in   [WAYS-1:0]  ways holding no valid line
//   resp_valid      out  response present
//   resp_ready      in   consumer accepts response
//   resp_hit        out  1 = hit, 0 = miss (victim returned)
//   resp_way        out  [WAY_W-1:0] hit way or victim way
//   resp_error      out  hit vector had more than one bit set
//
// Tree layout: node n (1..WAYS-1) is stored at bit n of a WAYS-bit vector;
// bit 0 is unused and always held at 0. Node n has children 2n and 2n+1.
// A node bit of 0 steers the victim toward the lower-index half.
// -----------------------------------------------------------------------------
module plru_way_controller #(
    parameter int WAYS = 8,
    parameter int SETS = 16,
    localparam int SET_W = (SETS > 1) ? $clog2(SETS) : 1,
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SET_W-1:0] req_set,
    input  logic [WAYS-1:0]  req_hit_vec,
    input  logic [WAYS-1:0]  req_invalid_vec,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_hit,
    output logic [WAY_W-1:0] resp_way,
    output logic             resp_error
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_DECIDE = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [WAY_W-1:0] lowest_idx(input logic [WAYS-1:0] v);
        logic [WAYS-1:0]  vv;
        logic [WAY_W-1:0] cnt;
        logic             found;
        lowest_idx = '0;
        vv         = v;
        cnt        = '0;
        found      = 1'b0;
        for (int i = 0; i < WAYS; i++) begin
            if (!found && vv[0]) begin
                lowest_idx = cnt;
                found      = 1'b1;
            end else begin
                found = found;
            end
            vv  = vv >> 1;
            cnt = cnt + WAY_W'(1);
        end
    endfunction

    // True when more than one bit is set.
    function automatic logic is_multi_hot(input logic [WAYS-1:0] v);
        is_multi_hot = ((v & (v - WAYS'(1))) != '0);
    endfunction

    // Walk from the root following each node bit down to a leaf. The way
    // index is assembled MSB first from the bits taken along the path.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-1:0] t);
        logic [WAY_W-1:0] node;
        logic [WAY_W-1:0] way;
        logic             b;
        node = WAY_W'(1);
        way  = '0;
        for (int l = 0; l < WAY_W; l++) begin
            b    = t[node];
            way  = WAY_W'({way, b});
            node = WAY_W'({node, b});
        end
        plru_victim = way;
    endfunction

    // Point every node on the path to way w away from it: a node gets 1
    // when w lies in its lower half, 0 when it lies in its upper half.
    function automatic logic [WAYS-1:0] plru_update(input logic [WAYS-1:0]  t,
                                                    input logic [WAY_W-1:0] w);
        logic [WAY_W-1:0] node;
        logic [WAY_W-1:0] ws;
        logic             dir;
        plru_update = t;
        node        = WAY_W'(1);
        ws          = w;
        for (int l = 0; l < WAY_W; l++) begin
            dir               = ws[WAY_W-1];
            plru_update[node] = ~dir;
            node              = WAY_W'({node, dir});
            ws                = ws << 1;
        end
        plru_update[0] = 1'b0;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_r;
    state_t             state_nxt_s;
    logic [SET_W-1:0]   set_r;
    logic [WAYS-1:0]    hit_vec_r;
    logic [WAYS-1:0]    work_r;
    logic [WAYS-1:0]    plru_r [SETS];
    logic               req_ready_r;
    logic               resp_valid_r;
    logic               resp_hit_r;
    logic [WAY_W-1:0]   resp_way_r;
    logic               resp_error_r;

    logic               hit_any_s;
    logic               multi_s;
    logic [WAY_W-1:0]   hit_way_s;
    logic [WAY_W-1:0]   victim_s;
    logic [WAY_W-1:0]   miss_way_s;
    logic [WAY_W-1:0]   chosen_way_s;
    logic               do_update_s;
    logic [WAYS-1:0]    new_bits_s;

`ifdef PLRU_INVALID_FIRST_EN
    logic [WAYS-1:0]    inv_vec_r;
`else
    // The invalid-way vector has no effect in this build.
    logic               unused_inv_s;
    assign unused_inv_s = ^req_invalid_vec;
`endif

    // Next-state decode for the lookup sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid && req_ready_r) begin
                    state_nxt_s = ST_READ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_READ:   state_nxt_s = ST_DECIDE;
            ST_DECIDE: state_nxt_s = ST_RESP;
            ST_RESP: begin
                if (resp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // Way selection from the captured vectors and the fetched PLRU bits.
    always_comb begin
        hit_any_s = |hit_vec_r;
        multi_s   = is_multi_hot(hit_vec_r);
        hit_way_s = lowest_idx(hit_vec_r);
        victim_s  = plru_victim(work_r);
`ifdef PLRU_INVALID_FIRST_EN
        if (|inv_vec_r) begin
            miss_way_s = lowest_idx(inv_vec_r);
        end else begin
            miss_way_s = victim_s;
        end
`else
        miss_way_s = victim_s;
`endif
        chosen_way_s = hit_any_s ? hit_way_s : miss_way_s;
        // A multi-hot hit is an upstream fault; leave the tree untouched.
        do_update_s  = !(hit_any_s && multi_s);
        new_bits_s   = plru_update(work_r, chosen_way_s);
    end

    // FSM state, request capture, working copy and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            set_r        <= '0;
            hit_vec_r    <= '0;
`ifdef PLRU_INVALID_FIRST_EN
            inv_vec_r    <= '0;
`endif
            work_r       <= '0;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_hit_r   <= 1'b0;
            resp_way_r   <= '0;
            resp_error_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            // Handshake outputs are registered copies of the next state.
            req_ready_r  <= (state_nxt_s == ST_IDLE);
            resp_valid_r <= (state_nxt_s == ST_RESP);
            if (state_r == ST_IDLE && req_valid && req_ready_r) begin
                set_r     <= req_set;
                hit_vec_r <= req_hit_vec;
`ifdef PLRU_INVALID_FIRST_EN
                inv_vec_r <= req_invalid_vec;
`endif
            end else begin
                set_r     <= set_r;
            end
            if (state_r == ST_READ) begin
                work_r <= plru_r[set_r];
            end else begin
                work_r <= work_r;
            end
            if (state_r == ST_DECIDE) begin
                resp_hit_r   <= hit_any_s;
                resp_way_r   <= chosen_way_s;
                resp_error_r <= hit_any_s && multi_s;
            end else begin
                resp_hit_r   <= resp_hit_r;
            end
        end
    end

    // Per-set PLRU storage; written once per lookup in DECIDE.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SETS; i++) begin
                plru_r[i] <= '0;
            end
        end else begin
            if (state_r == ST_DECIDE && do_update_s) begin
                plru_r[set_r] <= new_bits_s;
            end else begin
                plru_r[set_r] <= plru_r[set_r];
            end
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_hit   = resp_hit_r;
    assign resp_way   = resp_way_r;
    assign resp_error = resp_error_r;

endmodule

// File: tb/tb_plru_way_controller.sv
// -----------------------------------------------------------------------------
// Directed testbench for plru_way_controller (WAYS=8, SETS=16).
// Expected values are hand-derived from the tree PLRU rules.
// -----------------------------------------------------------------------------
module tb_plru_way_controller;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_set;
    logic [7:0] req_hit_vec;
    logic [7:0] req_invalid_vec;
    logic       resp_valid;
    logic       resp_ready;
    logic       resp_hit;
    logic [2:0] resp_way;
    logic       resp_error;

    int n_checks = 0;
    int n_pass   = 0;

    plru_way_controller #(.WAYS(8), .SETS(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_set         (req_set),
        .req_hit_vec     (req_hit_vec),
        .req_invalid_vec (req_invalid_vec),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_hit        (resp_hit),
        .resp_way        (resp_way),
        .resp_error      (resp_error)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one request and wait for it to be accepted.
    task automatic start_req(input logic [3:0] s, input logic [7:0] h, input logic [7:0] inv);
        int k;
        @(negedge clk);
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("req_ready_wait", 32'(req_ready), 32'd1);
        req_set         = s;
        req_hit_vec     = h;
        req_invalid_vec = inv;
        req_valid       = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Wait (bounded) until resp_valid is seen on a falling edge.
    task automatic wait_resp();
        int k;
        k = 0;
        @(negedge clk);
        while (!resp_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("resp_valid_wait", 32'(resp_valid), 32'd1);
    endtask

    // Complete the handshake on the next rising edge.
    task automatic take_resp();
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic lookup(input string tag, input logic [3:0] s, input logic [7:0] h,
                          input logic [7:0] inv, input logic exp_hit,
                          input logic [2:0] exp_way, input logic exp_err);
        start_req(s, h, inv);
        wait_resp();
        check({tag, "_hit"}, 32'(resp_hit), 32'(exp_hit));
        check({tag, "_way"}, 32'(resp_way), 32'(exp_way));
        check({tag, "_err"}, 32'(resp_error), 32'(exp_err));
        take_resp();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    logic [2:0] plru_seq [8];
    logic [2:0] held_way;
    logic       held_hit;

    initial begin
        reset           = 1'b1;
        req_valid       = 1'b0;
        req_set         = 4'd0;
        req_hit_vec     = 8'd0;
        req_invalid_vec = 8'd0;
        resp_ready      = 1'b0;
        plru_seq[0] = 3'd0; plru_seq[1] = 3'd4; plru_seq[2] = 3'd2; plru_seq[3] = 3'd6;
        plru_seq[4] = 3'd1; plru_seq[5] = 3'd5; plru_seq[6] = 3'd3; plru_seq[7] = 3'd7;

        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_req_ready",  32'(req_ready),  32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_hit",   32'(resp_hit),   32'd0);
        check("rst_resp_way",   32'(resp_way),   32'd0);
        check("rst_resp_error", 32'(resp_error), 32'd0);

        // PLRU victim order on set 3
        for (int i = 0; i < 8; i++) begin
            lookup("plru_order", 4'd3, 8'h00, 8'h00, 1'b0, plru_seq[i], 1'b0);
        end

        // Hit encode on set 5, then miss on set 5 and set 3
        lookup("hit5", 4'd5, 8'b0010_0000, 8'h00, 1'b1, 3'd5, 1'b0);
        lookup("miss5", 4'd5, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
        lookup("miss3_wrap", 4'd3, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
        // set 5 now has way 0 then way 5 recorded: next victim is way 4? no:
        // after way5 then way0 the root points up (1), node3=1 -> node7=0 -> way 6
        lookup("miss5_b", 4'd5, 8'h00, 8'h00, 1'b0, 3'd6, 1'b0);

        // Multi-hot leaves PLRU untouched
        do_reset();
        lookup("multi", 4'd7, 8'b0000_0110, 8'h00, 1'b1, 3'd1, 1'b1);
        lookup("multi_after", 4'd7, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);

        // Invalid-first (or ignored invalid vector)
        do_reset();
`ifdef PLRU_INVALID_FIRST_EN
        lookup("inv_first", 4'd9, 8'h00, 8'b1100_0000, 1'b0, 3'd6, 1'b0);
`else
        lookup("inv_ignored", 4'd9, 8'h00, 8'b1100_0000, 1'b0, 3'd0, 1'b0);
`endif

        // Backpressure on set 2 (fresh after reset: victim 0)
        start_req(4'd2, 8'h00, 8'h00);
        wait_resp();
        held_way = resp_way;
        held_hit = resp_hit;
        check("bp_way0", 32'(resp_way), 32'd0);
        for (int c = 0; c < 5; c++) begin
            req_set     = 4'd6;
            req_hit_vec = 8'h01;
            req_valid   = 1'b1;
            @(negedge clk);
            check("bp_valid",     32'(resp_valid), 32'd1);
            check("bp_req_ready", 32'(req_ready),  32'd0);
            check("bp_way",       32'(resp_way),   32'(held_way));
            check("bp_hit",       32'(resp_hit),   32'(held_hit));
        end
        req_valid = 1'b0;
        take_resp();
        @(negedge clk);
        check("bp_done_valid", 32'(resp_valid), 32'd0);
        check("bp_done_ready", 32'(req_ready),  32'd1);
        repeat (3) begin
            @(negedge clk);
            check("bp_no_extra", 32'(resp_valid), 32'd0);
        end
        lookup("bp_next", 4'd2, 8'h00, 8'h00, 1'b0, 3'd4, 1'b0);

        // Reset during DECIDE
        lookup("pre_dec", 4'd4, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
        start_req(4'd4, 8'h00, 8'h00);
        @(negedge clk);          // READ
        @(negedge clk);          // DECIDE
        reset = 1'b1;
        @(negedge clk);
        check("rst_dec_valid", 32'(resp_valid), 32'd0);
        check("rst_dec_ready", 32'(req_ready),  32'd1);
        reset = 1'b0;
        lookup("rst_dec_miss", 4'd4, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);

        // Reset during RESP
        start_req(4'd4, 8'h00, 8'h00);
        wait_resp();
        check("pre_resp_way", 32'(resp_way), 32'd4);
        reset = 1'b1;
        @(negedge clk);
        check("rst_resp_valid2", 32'(resp_valid), 32'd0);
        check("rst_resp_ready2", 32'(req_ready),  32'd1);
        reset = 1'b0;
        lookup("rst_resp_miss", 4'd4, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
